sdram_responder: RTL and testbench

SDRAM_RESPONDER -- requirements
Module: sdram_responder

---
 rtl/sdram_resp_pkg.sv | 52 +++++
 rtl/sdram_bank_tracker.sv | 70 +++++++
 rtl/sdram_responder.sv | 172 +++++++++++++++++
 tb/tb_sdram_responder.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_resp_pkg.sv
// Shared definitions for the SDRAM responder: command encodings, per-bank
// state, violation codes, geometry constants and the command decoder.
package sdram_resp_pkg;

  localparam int NUM_BANKS = 4;
  localparam int ROW_W     = 13;
  localparam int DATA_W    = 16;
  localparam int MEM_AW    = 6;   // {bank, row lsb, col[2:0]}

  // Values are the raw {cs_n,ras_n,cas_n,we_n} patterns.
  typedef enum logic [3:0] {
    CMD_LMR = 4'b0000,
    CMD_REF = 4'b0001,
    CMD_PRE = 4'b0010,
    CMD_ACT = 4'b0011,
    CMD_WR  = 4'b0100,
    CMD_RD  = 4'b0101,
    CMD_NOP = 4'b0111
  } cmd_e;

  typedef enum logic [1:0] {
    BANK_IDLE,
    BANK_ACTIVATING,
    BANK_ACTIVE,
    BANK_PRECHARGING
  } bank_st_e;

  typedef enum logic [2:0] {
    ERR_NONE      = 3'd0,
    ERR_ACT_OPEN  = 3'd1,  // ACTIVE to a bank that is not idle
    ERR_RW_CLOSED = 3'd2,  // READ/WRITE to an idle or precharging bank
    ERR_TIMING    = 3'd3,  // READ/WRITE too early, or command during refresh
    ERR_NOT_IDLE  = 3'd4   // REFRESH/LOAD MODE with a bank open
  } err_e;

  // Deselect and any unlisted pattern behave as NOP.
  function automatic cmd_e decode_cmd(input logic cs_n, input logic ras_n,
                                      input logic cas_n, input logic we_n);
    logic [3:0] raw;
    raw = {cs_n, ras_n, cas_n, we_n};
    case (raw)
      4'b0000: return CMD_LMR;
      4'b0001: return CMD_REF;
      4'b0010: return CMD_PRE;
      4'b0011: return CMD_ACT;
      4'b0100: return CMD_WR;
      4'b0101: return CMD_RD;
      default: return CMD_NOP;
    endcase
  endfunction

endpackage

// File: rtl/sdram_bank_tracker.sv
// Per-bank state tracker: IDLE/ACTIVATING/ACTIVE/PRECHARGING, open row and
// the tRCD/tRP timing counter.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   clock_enable    freezes all state when low
//   act, pre        accepted ACTIVE / PRECHARGE for this bank (already qualified)
//   row             row address captured on act
//   state, open_row current bank state and open row
module sdram_bank_tracker
  import sdram_resp_pkg::*;
#(
  parameter int TRCD = 2,
  parameter int TRP  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clock_enable,
  input  logic             act,
  input  logic             pre,
  input  logic [ROW_W-1:0] row,
  output bank_st_e         state,
  output logic [ROW_W-1:0] open_row
);

  localparam int TMAX = (TRCD > TRP) ? TRCD : TRP;
  // Counter only ever holds up to TMAX-1.
  localparam int CW   = (TMAX < 2) ? 1 : $clog2(TMAX);
  localparam int TRCD_LD = (TRCD > 1) ? TRCD - 1 : 0;
  localparam int TRP_LD  = (TRP > 1) ? TRP - 1 : 0;

  bank_st_e         state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [ROW_W-1:0] row_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= BANK_IDLE;
      cnt_q    <= '0;
      open_row <= '0;
    end else if (clock_enable) begin
      state    <= state_d;
      cnt_q    <= cnt_d;
      open_row <= row_d;
    end
  end

  // Counter is loaded with T-1 so the bank is usable exactly T cycles after
  // the command; a timing of 0 or 1 skips the transient state entirely.
  always_comb begin
    state_d = state;
    cnt_d   = cnt_q;
    row_d   = open_row;
    if (pre) begin
      state_d = (TRP <= 1) ? BANK_IDLE : BANK_PRECHARGING;
      cnt_d   = CW'(TRP_LD);
    end else if (act) begin
      row_d   = row;
      state_d = (TRCD <= 1) ? BANK_ACTIVE : BANK_ACTIVATING;
      cnt_d   = CW'(TRCD_LD);
    end else if (state == BANK_ACTIVATING || state == BANK_PRECHARGING) begin
      if (cnt_q <= CW'(1)) begin
        cnt_d   = '0;
        state_d = (state == BANK_ACTIVATING) ? BANK_ACTIVE : BANK_IDLE;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_responder.sv
// Behavioural SDRAM device responder: decodes the command bus, tracks four
// banks, stores data in a small 64x16 array, returns reads after CAS_LAT
// cycles and flags protocol violations.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   clock_enable               CKE; low freezes everything
//   cs_n/ras_n/cas_n/we_n      command bus
//   addr, bank_addr            row/column/all-bank flag, target bank
//   data_in, data_mask_*       write data and byte masks (1 = keep old byte)
//   data_out, data_oe          read data and its valid strobe
//   mode_reg                   last LOAD MODE value
//   refresh_cnt                accepted AUTO REFRESH count (wraps)
//   protocol_err, err_code     sticky violation flag and first violation code
module sdram_responder
  import sdram_resp_pkg::*;
#(
  parameter int CAS_LAT = 2,
  parameter int TRCD    = 2,
  parameter int TRP     = 2,
  parameter int TRFC    = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clock_enable,
  input  logic              cs_n,
  input  logic              ras_n,
  input  logic              cas_n,
  input  logic              we_n,
  input  logic [ROW_W-1:0]  addr,
  input  logic [1:0]        bank_addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_mask_low,
  input  logic              data_mask_high,
  output logic [DATA_W-1:0] data_out,
  output logic              data_oe,
  output logic [ROW_W-1:0]  mode_reg,
  output logic [15:0]       refresh_cnt,
  output logic              protocol_err,
  output logic [2:0]        err_code
);

  localparam int RFW = (TRFC < 1) ? 1 : $clog2(TRFC + 1);

  cmd_e                                 cmd;
  bank_st_e [NUM_BANKS-1:0]             bank_st;
  logic     [NUM_BANKS-1:0][ROW_W-1:0]  open_row;
  logic     [NUM_BANKS-1:0]             bank_act, bank_pre;
  bank_st_e                             sel_st;
  logic                                 all_idle;
  logic     [RFW-1:0]                   ref_busy_q;
  logic                                 ref_busy;
  err_e                                 viol;
  logic                                 accept, rd_ok, wr_ok, act_ok, pre_ok, ref_ok, lmr_ok;
  logic     [MEM_AW-1:0]                mem_idx;
  logic     [DATA_W-1:0]                rd_word;
  logic     [DATA_W-1:0]                mem [2**MEM_AW];
  logic     [CAS_LAT-1:0]               vld_pipe;
  logic     [CAS_LAT-1:0][DATA_W-1:0]   dat_pipe;
  logic                                 unused_row;

  assign cmd      = decode_cmd(cs_n, ras_n, cas_n, we_n);
  assign sel_st   = bank_st[bank_addr];
  assign ref_busy = |ref_busy_q;

  always_comb begin
    all_idle = 1'b1;
    for (int b = 0; b < NUM_BANKS; b++)
      if (bank_st[b] != BANK_IDLE) all_idle = 1'b0;
  end

  // Refresh-busy has priority: it rejects everything, whatever the banks say.
  always_comb begin
    viol = ERR_NONE;
    if (ref_busy && cmd != CMD_NOP) begin
      viol = ERR_TIMING;
    end else begin
      case (cmd)
        CMD_ACT:         if (sel_st != BANK_IDLE) viol = ERR_ACT_OPEN;
        CMD_RD, CMD_WR: begin
          if (sel_st == BANK_ACTIVATING)  viol = ERR_TIMING;
          else if (sel_st != BANK_ACTIVE) viol = ERR_RW_CLOSED;
        end
        CMD_REF, CMD_LMR: if (!all_idle) viol = ERR_NOT_IDLE;
        default: ;
      endcase
    end
  end

  // A violating command is dropped; only its error is recorded.
  assign accept = clock_enable && (viol == ERR_NONE);
  assign rd_ok  = accept && (cmd == CMD_RD);
  assign wr_ok  = accept && (cmd == CMD_WR);
  assign act_ok = accept && (cmd == CMD_ACT);
  assign pre_ok = accept && (cmd == CMD_PRE);
  assign ref_ok = accept && (cmd == CMD_REF);
  assign lmr_ok = accept && (cmd == CMD_LMR);

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    assign bank_act[b] = act_ok && (bank_addr == 2'(b));
    assign bank_pre[b] = pre_ok && (addr[10] || bank_addr == 2'(b));

    sdram_bank_tracker #(
      .TRCD (TRCD),
      .TRP  (TRP)
    ) u_trk (
      .clk          (clk),
      .rst_n        (rst_n),
      .clock_enable (clock_enable),
      .act          (bank_act[b]),
      .pre          (bank_pre[b]),
      .row          (addr),
      .state        (bank_st[b]),
      .open_row     (open_row[b])
    );
  end

  // Only the row lsb participates in array addressing.
  always_comb begin
    unused_row = 1'b0;
    for (int b = 0; b < NUM_BANKS; b++) unused_row = unused_row ^ (^open_row[b][ROW_W-1:1]);
  end

  assign mem_idx = {bank_addr, open_row[bank_addr][0], addr[2:0]};
  assign rd_word = mem[mem_idx];

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      if (!data_mask_low)  mem[mem_idx][7:0]  <= data_in[7:0];
      if (!data_mask_high) mem[mem_idx][15:8] <= data_in[15:8];
    end
  end

  // Read pipeline: the array is sampled on the READ edge, so a WRITE issued
  // while the read is in flight cannot change the returned word. Idle stages
  // carry zero so data_out is 0 whenever data_oe is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else if (clock_enable) begin
      vld_pipe <= {vld_pipe[CAS_LAT-2:0], rd_ok};
      dat_pipe <= {dat_pipe[CAS_LAT-2:0], (rd_ok ? rd_word : {DATA_W{1'b0}})};
    end
  end

  assign data_out = dat_pipe[CAS_LAT-1];
  assign data_oe  = vld_pipe[CAS_LAT-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_busy_q   <= '0;
      refresh_cnt  <= '0;
      mode_reg     <= '0;
      protocol_err <= 1'b0;
      err_code     <= 3'd0;
    end else if (clock_enable) begin
      if (ref_ok) begin
        refresh_cnt <= refresh_cnt + 16'd1;
        ref_busy_q  <= RFW'(TRFC);
      end else if (ref_busy) begin
        ref_busy_q <= ref_busy_q - 1'b1;
      end
      if (lmr_ok) mode_reg <= addr;
      if (viol != ERR_NONE && !protocol_err) begin
        protocol_err <= 1'b1;
        err_code     <= viol;
      end
    end
  end

endmodule

// File: tb/tb_sdram_responder.sv
// Bench for sdram_responder: directed scenarios then randomized traffic,
// all checked against a cycle-count based reference model.
module tb_sdram_responder;

  localparam int CL = 2, TRCD = 2, TRP = 2, TRFC = 7;
  localparam logic [3:0] C_NOP = 4'b0111, C_ACT = 4'b0011, C_RD  = 4'b0101,
                         C_WR  = 4'b0100, C_PRE = 4'b0010, C_REF = 4'b0001,
                         C_LMR = 4'b0000, C_DES = 4'b1111;

  logic        clk = 1'b0, rst_n = 1'b1, clock_enable = 1'b1;
  logic        cs_n = 1'b0, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
  logic [12:0] addr = '0;
  logic [1:0]  bank_addr = '0;
  logic [15:0] data_in = '0;
  logic        data_mask_low = 1'b0, data_mask_high = 1'b0;
  logic [15:0] data_out;
  logic        data_oe;
  logic [12:0] mode_reg;
  logic [15:0] refresh_cnt;
  logic        protocol_err;
  logic [2:0]  err_code;

  sdram_responder #(.CAS_LAT(CL), .TRCD(TRCD), .TRP(TRP), .TRFC(TRFC)) dut (
    .clk(clk), .rst_n(rst_n), .clock_enable(clock_enable),
    .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
    .addr(addr), .bank_addr(bank_addr), .data_in(data_in),
    .data_mask_low(data_mask_low), .data_mask_high(data_mask_high),
    .data_out(data_out), .data_oe(data_oe), .mode_reg(mode_reg),
    .refresh_cnt(refresh_cnt), .protocol_err(protocol_err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int passes = 0, total = 0;

  // ---------------- reference model ----------------
  // Bank state is derived from how many enabled cycles have elapsed since
  // the last ACTIVE / PRECHARGE / REFRESH, not from any state machine.
  int          k;                       // enabled clock edges since reset
  bit          open_m [4];
  int          act_at [4], pre_at [4];
  bit          row0_m [4];
  int          ref_at;
  logic [15:0] mem_m [64];
  bit          kn_lo [64], kn_hi [64];
  bit          exp_oe [int];
  logic [15:0] exp_do [int], exp_km [int];
  logic [12:0] mode_m;
  logic [15:0] rcnt_m;
  bit          perr_m;
  logic [2:0]  ecode_m;

  function automatic int bst(int b);    // 0 idle, 1 activating, 2 active, 3 precharging
    if (open_m[b]) return (k - act_at[b] >= TRCD) ? 2 : 1;
    return (k - pre_at[b] >= TRP) ? 0 : 3;
  endfunction

  function automatic bit busy_m();
    return (k - ref_at >= 1) && (k - ref_at <= TRFC);
  endfunction

  function automatic bit all_idle_m();
    for (int b = 0; b < 4; b++) if (bst(b) != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    k = 0; ref_at = -1000; mode_m = '0; rcnt_m = '0; perr_m = 0; ecode_m = '0;
    for (int b = 0; b < 4; b++) begin
      open_m[b] = 0; act_at[b] = -1000; pre_at[b] = -1000; row0_m[b] = 0;
    end
    exp_oe.delete(); exp_do.delete(); exp_km.delete();
  endtask

  task automatic model_edge(input logic ce, input logic [3:0] c, input logic [1:0] b,
                            input logic [12:0] a, input logic [15:0] d,
                            input logic lo, input logic hi);
    int v, idx, bi;
    logic [3:0] eff;
    if (!ce) return;
    bi  = int'(b);
    eff = (c[3] || c == 4'b0110) ? C_NOP : c;
    v   = 0;
    if (busy_m() && eff != C_NOP) v = 3;
    else case (eff)
      C_ACT:       if (bst(bi) != 0) v = 1;
      C_RD, C_WR:  if (bst(bi) == 1) v = 3; else if (bst(bi) != 2) v = 2;
      C_REF, C_LMR: if (!all_idle_m()) v = 4;
      default: ;
    endcase
    if (v != 0) begin
      if (!perr_m) begin perr_m = 1; ecode_m = 3'(v); end
    end else begin
      idx = bi * 16 + int'(row0_m[bi]) * 8 + int'(a[2:0]);
      case (eff)
        C_ACT: begin open_m[bi] = 1; act_at[bi] = k; row0_m[bi] = a[0]; end
        C_PRE: for (int i = 0; i < 4; i++)
                 if (a[10] || i == bi) begin open_m[i] = 0; pre_at[i] = k; end
        C_RD: begin
          exp_oe[k + CL] = 1;
          exp_do[k + CL] = mem_m[idx];
          exp_km[k + CL] = {{8{kn_hi[idx]}}, {8{kn_lo[idx]}}};
        end
        C_WR: begin
          if (!lo) begin mem_m[idx][7:0]  = d[7:0];  kn_lo[idx] = 1; end
          if (!hi) begin mem_m[idx][15:8] = d[15:8]; kn_hi[idx] = 1; end
        end
        C_REF: begin rcnt_m = rcnt_m + 16'd1; ref_at = k; end
        C_LMR: mode_m = a;
        default: ;
      endcase
    end
    k++;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic check_all();
    logic [15:0] km;
    if (exp_oe.exists(k)) begin
      km = exp_km[k];
      chk("data_oe", 32'(data_oe), 32'd1);
      chk("data_out", 32'(data_out & km), 32'(exp_do[k] & km));
    end else begin
      chk("data_oe", 32'(data_oe), 32'd0);
      chk("data_out_idle", 32'(data_out), 32'd0);
    end
    chk("mode_reg", 32'(mode_reg), 32'(mode_m));
    chk("refresh_cnt", 32'(refresh_cnt), 32'(rcnt_m));
    chk("protocol_err", 32'(protocol_err), 32'(perr_m));
    chk("err_code", 32'(err_code), 32'(ecode_m));
  endtask

  // One clock: drive at the falling edge, let the DUT see it on the rising
  // edge, advance the model, check at the next falling edge.
  task automatic cyc(input logic ce, input logic [3:0] c, input logic [1:0] b,
                     input logic [12:0] a, input logic [15:0] d,
                     input logic lo, input logic hi);
    clock_enable = ce; {cs_n, ras_n, cas_n, we_n} = c;
    bank_addr = b; addr = a; data_in = d; data_mask_low = lo; data_mask_high = hi;
    @(posedge clk);
    model_edge(ce, c, b, a, d, lo, hi);
    @(negedge clk);
    check_all();
  endtask

  task automatic nop();
    cyc(1'b1, C_NOP, 2'd0, 13'd0, 16'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_data_oe", 32'(data_oe), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_mode_reg", 32'(mode_reg), 32'd0);
    chk("rst_refresh_cnt", 32'(refresh_cnt), 32'd0);
    chk("rst_protocol_err", 32'(protocol_err), 32'd0);
    chk("rst_err_code", 32'(err_code), 32'd0);
    model_reset();
    @(negedge clk);
    clock_enable = 1'b1; {cs_n, ras_n, cas_n, we_n} = C_NOP;
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  c;
    logic [1:0]  b;
    logic [12:0] a;
    logic        ce;
    int          r;
    for (int i = 0; i < 64; i++) begin mem_m[i] = '0; kn_lo[i] = 0; kn_hi[i] = 0; end
    model_reset();
    @(negedge clk);
    do_reset();

    // Write then read back with CAS latency 2.
    cyc(1, C_ACT, 2'd0, 13'd5, 16'd0, 0, 0);
    nop();
    cyc(1, C_WR, 2'd0, 13'd3, 16'hA5C3, 0, 0);
    cyc(1, C_RD, 2'd0, 13'd3, 16'd0, 0, 0);
    chk("r026_oe_n1", 32'(data_oe), 32'd0);
    nop();
    chk("r026_oe_n2", 32'(data_oe), 32'd1);
    chk("r026_data", 32'(data_out), 32'hA5C3);
    nop();
    chk("r026_oe_n3", 32'(data_oe), 32'd0);

    // High byte mask keeps the old upper byte.
    cyc(1, C_WR, 2'd0, 13'd4, 16'hFFFF, 0, 0);
    cyc(1, C_WR, 2'd0, 13'd4, 16'h1234, 0, 1);
    cyc(1, C_RD, 2'd0, 13'd4, 16'd0, 0, 0);
    nop();
    chk("r027_data", 32'(data_out), 32'hFF34);
    nop();

    // Read in flight is held while CKE is low.
    cyc(1, C_RD, 2'd0, 13'd3, 16'd0, 0, 0);
    cyc(0, C_RD, 2'd0, 13'd4, 16'd0, 0, 0);
    chk("r030_frozen_oe", 32'(data_oe), 32'd0);
    cyc(1, C_RD, 2'd0, 13'd4, 16'd0, 0, 0);
    chk("r030_first_oe", 32'(data_oe), 32'd1);
    chk("r030_first", 32'(data_out), 32'hA5C3);
    nop();
    chk("r030_second_oe", 32'(data_oe), 32'd1);
    chk("r030_second", 32'(data_out), 32'hFF34);
    nop();
    chk("r030_after_oe", 32'(data_oe), 32'd0);

    // Read to an idle bank, then a second violation does not overwrite.
    cyc(1, C_RD, 2'd1, 13'd0, 16'd0, 0, 0);
    chk("r028_err", 32'(protocol_err), 32'd1);
    chk("r028_code", 32'(err_code), 32'd2);
    nop(); nop();
    chk("r028_no_oe", 32'(data_oe), 32'd0);
    cyc(1, C_ACT, 2'd0, 13'd9, 16'd0, 0, 0);
    chk("r028_code_kept", 32'(err_code), 32'd2);

    // Refresh counter wrap and command during refresh busy.
    do_reset();
    force dut.refresh_cnt = 16'hFFFF;
    #1;
    release dut.refresh_cnt;
    rcnt_m = 16'hFFFF;
    cyc(1, C_REF, 2'd0, 13'd0, 16'd0, 0, 0);
    chk("r029_wrap", 32'(refresh_cnt), 32'd0);
    nop(); nop();
    cyc(1, C_ACT, 2'd2, 13'd1, 16'd0, 0, 0);
    chk("r029_err", 32'(protocol_err), 32'd1);
    chk("r029_code", 32'(err_code), 32'd3);

    // Reset in the middle of a read discards it.
    do_reset();
    cyc(1, C_LMR, 2'd0, 13'h123, 16'd0, 0, 0);
    chk("lmr_value", 32'(mode_reg), 32'h123);
    cyc(1, C_ACT, 2'd2, 13'd7, 16'd0, 0, 0);
    nop();
    cyc(1, C_RD, 2'd2, 13'd1, 16'd0, 0, 0);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      nop();
      chk("r031_no_oe", 32'(data_oe), 32'd0);
    end

    // Randomized traffic, mostly legal, in segments separated by reset.
    for (int seg = 0; seg < 6; seg++) begin
      do_reset();
      for (int i = 0; i < 250; i++) begin
        ce = ($urandom_range(0, 99) >= 8);
        b  = 2'($urandom_range(0, 3));
        a  = 13'($urandom);
        r  = $urandom_range(0, 99);
        if (r < 5) begin
          case ($urandom_range(0, 7))
            0: c = C_NOP; 1: c = C_ACT; 2: c = C_RD;  3: c = C_WR;
            4: c = C_PRE; 5: c = C_REF; 6: c = C_LMR; default: c = C_DES;
          endcase
        end else if (busy_m()) begin
          c = (r < 50) ? C_NOP : C_DES;
        end else begin
          case (bst(int'(b)))
            0: c = (r < 55) ? C_ACT :
                   (r < 65 && all_idle_m()) ? C_REF :
                   (r < 70 && all_idle_m()) ? C_LMR : C_NOP;
            2: c = (r < 40) ? C_RD : (r < 75) ? C_WR : (r < 88) ? C_PRE : C_NOP;
            default: c = C_NOP;
          endcase
        end
        if (c == C_PRE) a[10] = ($urandom_range(0, 4) == 0);
        cyc(ce, c, b, a, 16'($urandom),
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
      end
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
